nic_core: RTL and testbench



---
 rtl/nic_core.sv | 169 ++++++++++++++++
 tb/tb_nic_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_core.sv
`default_nettype none
// ============================================================================
// Module  : nic_core
// Brief   : Parametrised accumulator CPU datapath with handshaked memory
//           port, buffered valid/ready output and HALT.
//           Optional NIC_CORE_PERF_EN adds retired/stalls counters.
// Revision: 1.0 - initial release
// ============================================================================
module nic_core #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          halted
`ifdef NIC_CORE_PERF_EN
    ,
    output logic [31:0]   retired,
    output logic [31:0]   stalls
`endif
);

    localparam logic [1:0] SRC_MEM = 2'd0;
    localparam logic [1:0] SRC_ALU = 2'd1;
    localparam logic [1:0] SRC_A   = 2'd2;
    localparam logic [1:0] SRC_X   = 2'd3;

    localparam logic [2:0] DST_IR    = 3'd0;
    localparam logic [2:0] DST_PC    = 3'd1;
    localparam logic [2:0] DST_A     = 3'd2;
    localparam logic [2:0] DST_X     = 3'd3;
    localparam logic [2:0] DST_B     = 3'd4;
    localparam logic [2:0] DST_STORE = 3'd5;
    localparam logic [2:0] DST_OUT   = 3'd6;
    localparam logic [2:0] DST_HALT  = 3'd7;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [7:0]    ir;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [DW-1:0] x_reg;
    logic          carry;

    logic          c7;
    logic          c6;
    logic [1:0]    src;
    logic [2:0]    dst;
    logic          idx;

    assign c7  = ir[7];
    assign c6  = ir[6];
    assign src = ir[5:4];
    assign dst = ir[3:1];
    assign idx = ir[0];

    logic [DW:0]   sum;
    logic [DW-1:0] alu_res;
    logic          alu_carry;

    assign sum       = {1'b0, a_reg} + {1'b0, b_reg};
    assign alu_res   = c6 ? (a_reg - b_reg) : sum[DW-1:0];
    assign alu_carry = c6 ? !(b_reg > a_reg) : sum[DW];

    logic [DW-1:0] dbus;

    always_comb begin
        dbus = mem_rdata;
        case (src)
            SRC_MEM: dbus = mem_rdata;
            SRC_ALU: dbus = alu_res;
            SRC_A:   dbus = a_reg;
            SRC_X:   dbus = x_reg;
            default: dbus = mem_rdata;
        endcase
    end

    logic running;
    logic needs_mem;
    logic out_block;
    logic commit;
    logic jump_taken;
    logic [AW-1:0] pc_next;

    assign running   = (state == ST_RUN);
    assign needs_mem = (src == SRC_MEM) || (dst == DST_STORE);
    assign out_block = (dst == DST_OUT) && out_valid && !out_ready;
    assign commit    = running && !out_block && (!needs_mem || mem_ready);

    assign jump_taken = (c6 && (a_reg == '0)) || (c7 && carry) || (c6 && c7);
    assign pc_next    = ((dst == DST_PC) && jump_taken) ? dbus[AW-1:0]
                      : (idx ? pc : pc + AW'(1));

    assign mem_req  = running && needs_mem && !out_block;
    assign mem_we   = mem_req && (dst == DST_STORE);
    assign mem_addr = idx ? x_reg[AW-1:0] : pc;
    // Memory source never drives a store, so that leg reads as zero.
    assign mem_wdata = (src == SRC_MEM) ? '0 : dbus;
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            pc        <= '0;
            ir        <= 8'h00;
            a_reg     <= '0;
            b_reg     <= '0;
            x_reg     <= '0;
            carry     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (commit) begin
                pc <= pc_next;
                ir <= (dst == DST_IR) ? dbus[7:0] : 8'h00;
                if (src == SRC_ALU) begin
                    carry <= alu_carry;
                end
                case (dst)
                    DST_A:    a_reg <= dbus;
                    DST_X:    x_reg <= dbus;
                    DST_B:    b_reg <= dbus;
                    DST_HALT: state <= ST_HALT;
                    default:  ;
                endcase
            end
            // A push wins over a same-cycle pop so the buffer stays full.
            if (commit && (dst == DST_OUT)) begin
                out_data  <= dbus;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NIC_CORE_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= 32'd0;
            stalls  <= 32'd0;
        end else begin
            if (commit) begin
                retired <= retired + 32'd1;
            end
            if (running && !commit) begin
                stalls <= stalls + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_nic_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_nic_core
// Brief   : Directed self-checking bench for nic_core (DW=8/AW=8 and DW=16/AW=12).
// Revision: 1.0 - initial release
// ============================================================================
module tb_nic_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        halted;
`ifdef NIC_CORE_PERF_EN
    logic [31:0] retired;
    logic [31:0] stalls;
`endif

    logic        mem_req16;
    logic        mem_we16;
    logic [11:0] mem_addr16;
    logic [15:0] mem_wdata16;
    logic [15:0] mem_rdata16;
    logic [15:0] out_data16;
    logic        out_valid16;
    logic        halted16;
    logic        mem_ready16 = 1'b1;
    logic        out_ready16 = 1'b0;
`ifdef NIC_CORE_PERF_EN
    logic [31:0] retired16;
    logic [31:0] stalls16;
`endif

    logic [7:0]  mem   [0:255];
    logic [15:0] mem16 [0:63];
    logic        ws_en;
    logic [1:0]  wcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr];
    assign mem_rdata16 = mem16[mem_addr16[5:0]];
    assign mem_ready   = ws_en ? (mem_req && (wcnt == 2'd3)) : 1'b1;

    // Wait-state generator: three refused cycles ahead of each access.
    always @(posedge clk) begin
        if (!reset_n)
            wcnt <= 2'd0;
        else if (mem_req && !mem_ready)
            wcnt <= wcnt + 2'd1;
        else
            wcnt <= 2'd0;
    end

    nic_core #(.DW(8), .AW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted)
`ifdef NIC_CORE_PERF_EN
        ,
        .retired   (retired),
        .stalls    (stalls)
`endif
    );

    nic_core #(.DW(16), .AW(12)) dut16 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem_req16),
        .mem_we    (mem_we16),
        .mem_addr  (mem_addr16),
        .mem_wdata (mem_wdata16),
        .mem_rdata (mem_rdata16),
        .mem_ready (mem_ready16),
        .out_data  (out_data16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .halted    (halted16)
`ifdef NIC_CORE_PERF_EN
        ,
        .retired   (retired16),
        .stalls    (stalls16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input logic [63:0] p, input logic [7:0] at10);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = p[63-8*i -: 8];
        mem[16] = at10;
    endtask

    task automatic restart(input logic [63:0] p, input logic [7:0] at10);
        @(negedge clk);
        reset_n = 1'b0;
        load_prog(p, at10);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_to_halt(output int n, input int limit);
        n = 0;
        while (!halted && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int          n;
        logic        prev_stall;
        logic [7:0]  prev_addr;

        reset_n   = 1'b0;
        out_ready = 1'b0;
        ws_en     = 1'b0;
        for (int i = 0; i < 64; i++) mem16[i] = 16'h0000;
        mem16[0] = 16'h0004; mem16[1] = 16'h0005; mem16[2] = 16'h0008;
        mem16[3] = 16'h0003; mem16[4] = 16'h001D; mem16[5] = 16'h002F;
        load_prog(64'h04_05_08_03_1D_2F_00_00, 8'h00);

        // Reset state
        run_cycles(2);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data, 8'h00);
        check("rst_halted",    halted, 1'b0);
        check("rst_mem_req",   mem_req, 1'b1);
        check("rst_mem_we",    mem_we, 1'b0);
        check("rst_mem_addr",  mem_addr, 8'h00);
        reset_n = 1'b1;

        // Add, both widths in parallel
        run_to_halt(n, 100);
        check("add_cycles",    n, 8);
        check("add_out_data",  out_data, 8'h08);
        check("add_out_valid", out_valid, 1'b1);
        check("add_halted",    halted, 1'b1);
        check("add_pc",        mem_addr, 8'h06);
        check("add_halt_req",  mem_req, 1'b0);
`ifdef NIC_CORE_PERF_EN
        check("add_retired",   retired, 32'd8);
        check("add_stalls",    stalls, 32'd0);
`endif
        check("w16_out_data",  out_data16, 16'h0008);
        check("w16_out_valid", out_valid16, 1'b1);
        check("w16_halted",    halted16, 1'b1);
        check("w16_pc",        mem_addr16, 12'h006);

        // Subtract, carry observed via jump-on-carry (taken lands at 0x10)
        restart(64'h04_05_08_03_5D_82_10_2F, 8'h2F);
        run_to_halt(n, 100);
        check("sub_cycles",    n, 10);
        check("sub_out_data",  out_data, 8'h02);
        check("sub_carry_pc",  mem_addr, 8'h11);
        restart(64'h04_03_08_05_5D_82_10_2F, 8'h2F);
        run_to_halt(n, 100);
        check("subn_out_data", out_data, 8'hFE);
        check("subn_carry_pc", mem_addr, 8'h08);

        // Memory wait states
        ws_en = 1'b1;
        restart(64'h04_05_08_03_1D_2F_00_00, 8'h00);
        n = 0;
        prev_stall = 1'b0;
        prev_addr  = 8'h00;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
            if (prev_stall) check("ws_addr_stable", mem_addr, prev_addr);
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
        end
        check("ws_cycles",    n, 26);
        check("ws_out_data",  out_data, 8'h08);
        check("ws_out_valid", out_valid, 1'b1);
        check("ws_pc",        mem_addr, 8'h06);
`ifdef NIC_CORE_PERF_EN
        check("ws_retired",   retired, 32'd8);
        check("ws_stalls",    stalls, 32'd18);
`endif
        ws_en = 1'b0;

        // Jumps
        restart(64'hC2_10_00_00_00_00_00_00, 8'h2F);
        run_cycles(2);
        check("jmp_uncond_pc", mem_addr, 8'h10);
        restart(64'h42_20_00_00_00_00_00_00, 8'h00);
        run_cycles(2);
        check("jmpz_taken_pc", mem_addr, 8'h20);
        restart(64'h04_01_42_20_2F_00_00_00, 8'h00);
        run_cycles(4);
        check("jmpz_skip_pc",  mem_addr, 8'h04);
        run_to_halt(n, 20);
        check("jmpz_skip_halt", halted, 1'b1);

        // Output backpressure: second OUT (memory source) must stall
        restart(64'h04_05_08_03_1D_0C_77_2F, 8'h00);
        run_cycles(7);
        check("bp_valid",     out_valid, 1'b1);
        check("bp_data",      out_data, 8'h08);
        check("bp_req",       mem_req, 1'b0);
        check("bp_addr",      mem_addr, 8'h06);
        run_cycles(1);
        check("bp_req_hold",  mem_req, 1'b0);
        check("bp_data_hold", out_data, 8'h08);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_swap_data",  out_data, 8'h77);
        check("bp_swap_valid", out_valid, 1'b1);
        run_to_halt(n, 20);
        check("bp_halt_cycles", n, 2);
        check("bp_halt_valid",  out_valid, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_drain_valid", out_valid, 1'b0);
        check("bp_drain_halt",  halted, 1'b1);

        // Asynchronous reset mid-stall with a full output buffer
        restart(64'h04_05_08_03_1D_0C_77_2F, 8'h00);
        run_cycles(7);
        check("ar_pre_valid", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_out_data",  out_data, 8'h00);
        check("ar_halted",    halted, 1'b0);
        check("ar_mem_req",   mem_req, 1'b1);
        check("ar_mem_we",    mem_we, 1'b0);
        check("ar_mem_addr",  mem_addr, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        run_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
